// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - 8N1 UART receiver with 6-byte command frame parser
module uart_cmd_rx #(
    parameter int          CLK_FREQ       = 12_000_000,
    parameter int          BAUD           = 1_000_000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd120000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [7:0]  rx_byte,
    output logic        rx_byte_valid,
    output logic        cmd_valid,
    output logic [7:0]  cmd_op,
    output logic [15:0] cmd_val,
    output logic        frame_err,
    output logic        cksum_err
);

    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB + 1);
    localparam logic [CW-1:0] CNT_BIT  = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

    typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_STOP, B_WAIT_HI} bit_state_t;
    typedef enum logic [2:0] {P_SYNC0, P_SYNC1, P_OP, P_VH, P_VL, P_CK} parse_state_t;

    logic         rx_meta_q, rx_s_q;
    bit_state_t   bit_state_q, bit_state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]   bit_idx_q, bit_idx_d;
    logic [7:0]   sreg_q, sreg_d;
    logic [7:0]   rx_byte_q, rx_byte_d;
    logic         rx_byte_valid_q, rx_byte_valid_d;
    logic         frame_err_q, frame_err_d;

    parse_state_t parse_state_q, parse_state_d;
    logic [7:0]   op_stg_q, op_stg_d;
    logic [7:0]   vh_stg_q, vh_stg_d;
    logic [7:0]   vl_stg_q, vl_stg_d;
    logic [7:0]   cmd_op_q, cmd_op_d;
    logic [15:0]  cmd_val_q, cmd_val_d;
    logic         cmd_valid_q, cmd_valid_d;
    logic         cksum_err_q, cksum_err_d;
    logic [23:0]  timer_q, timer_d;

    always_comb begin
        bit_state_d     = bit_state_q;
        cnt_d           = cnt_q + 1'b1;
        bit_idx_d       = bit_idx_q;
        sreg_d          = sreg_q;
        rx_byte_d       = rx_byte_q;
        rx_byte_valid_d = 1'b0;
        frame_err_d     = 1'b0;
        case (bit_state_q)
            B_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) bit_state_d = B_START;
            end
            B_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d       = '0;
                    bit_idx_d   = '0;
                    bit_state_d = rx_s_q ? B_IDLE : B_DATA;
                end
            end
            B_DATA: begin
                if (cnt_q == CNT_BIT) begin
                    cnt_d     = '0;
                    sreg_d    = {rx_s_q, sreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) bit_state_d = B_STOP;
                end
            end
            B_STOP: begin
                if (cnt_q == CNT_BIT) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        rx_byte_d       = sreg_q;
                        rx_byte_valid_d = 1'b1;
                        bit_state_d     = B_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        bit_state_d = B_WAIT_HI;
                    end
                end
            end
            B_WAIT_HI: begin
                cnt_d = '0;
                if (rx_s_q) bit_state_d = B_IDLE;
            end
            default: begin
                cnt_d       = '0;
                bit_state_d = B_IDLE;
            end
        endcase
    end

    // Parser consumes the registered byte strobe, so command outputs lag it by one cycle.
    always_comb begin
        parse_state_d = parse_state_q;
        op_stg_d      = op_stg_q;
        vh_stg_d      = vh_stg_q;
        vl_stg_d      = vl_stg_q;
        cmd_op_d      = cmd_op_q;
        cmd_val_d     = cmd_val_q;
        cmd_valid_d   = 1'b0;
        cksum_err_d   = 1'b0;
        timer_d       = (rx_byte_valid_q || parse_state_q == P_SYNC0) ? 24'd0 : timer_q + 24'd1;
        if (frame_err_q) begin
            parse_state_d = P_SYNC0;
        end else if (rx_byte_valid_q) begin
            case (parse_state_q)
                P_SYNC0: if (rx_byte_q == 8'h55) parse_state_d = P_SYNC1;
                P_SYNC1: begin
                    if (rx_byte_q == 8'hAA)      parse_state_d = P_OP;
                    else if (rx_byte_q != 8'h55) parse_state_d = P_SYNC0;
                end
                P_OP: begin
                    op_stg_d      = rx_byte_q;
                    parse_state_d = P_VH;
                end
                P_VH: begin
                    vh_stg_d      = rx_byte_q;
                    parse_state_d = P_VL;
                end
                P_VL: begin
                    vl_stg_d      = rx_byte_q;
                    parse_state_d = P_CK;
                end
                P_CK: begin
                    if (rx_byte_q == (op_stg_q ^ vh_stg_q ^ vl_stg_q)) begin
                        cmd_op_d    = op_stg_q;
                        cmd_val_d   = {vh_stg_q, vl_stg_q};
                        cmd_valid_d = 1'b1;
                    end else begin
                        cksum_err_d = 1'b1;
                    end
                    parse_state_d = P_SYNC0;
                end
                default: parse_state_d = P_SYNC0;
            endcase
        end else if (timer_q >= TIMEOUT_CYCLES) begin
            parse_state_d = P_SYNC0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q       <= 1'b1;
            rx_s_q          <= 1'b1;
            bit_state_q     <= B_IDLE;
            cnt_q           <= '0;
            bit_idx_q       <= '0;
            sreg_q          <= '0;
            rx_byte_q       <= '0;
            rx_byte_valid_q <= 1'b0;
            frame_err_q     <= 1'b0;
            parse_state_q   <= P_SYNC0;
            op_stg_q        <= '0;
            vh_stg_q        <= '0;
            vl_stg_q        <= '0;
            cmd_op_q        <= '0;
            cmd_val_q       <= '0;
            cmd_valid_q     <= 1'b0;
            cksum_err_q     <= 1'b0;
            timer_q         <= '0;
        end else begin
            rx_meta_q       <= rx;
            rx_s_q          <= rx_meta_q;
            bit_state_q     <= bit_state_d;
            cnt_q           <= cnt_d;
            bit_idx_q       <= bit_idx_d;
            sreg_q          <= sreg_d;
            rx_byte_q       <= rx_byte_d;
            rx_byte_valid_q <= rx_byte_valid_d;
            frame_err_q     <= frame_err_d;
            parse_state_q   <= parse_state_d;
            op_stg_q        <= op_stg_d;
            vh_stg_q        <= vh_stg_d;
            vl_stg_q        <= vl_stg_d;
            cmd_op_q        <= cmd_op_d;
            cmd_val_q       <= cmd_val_d;
            cmd_valid_q     <= cmd_valid_d;
            cksum_err_q     <= cksum_err_d;
            timer_q         <= timer_d;
        end
    end

    assign rx_byte       = rx_byte_q;
    assign rx_byte_valid = rx_byte_valid_q;
    assign frame_err     = frame_err_q;
    assign cmd_op        = cmd_op_q;
    assign cmd_val       = cmd_val_q;
    assign cmd_valid     = cmd_valid_q;
    assign cksum_err     = cksum_err_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb/tb_uart_cmd_rx.sv - scoreboard bench for uart_cmd_rx
module tb_uart_cmd_rx;

    localparam int CPB = 12;
    localparam int TMO = 600;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [7:0]  rx_byte;
    logic        rx_byte_valid;
    logic        cmd_valid;
    logic [7:0]  cmd_op;
    logic [15:0] cmd_val;
    logic        frame_err;
    logic        cksum_err;

    uart_cmd_rx #(
        .CLK_FREQ(12_000_000),
        .BAUD(1_000_000),
        .TIMEOUT_CYCLES(24'(TMO))
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .rx_byte(rx_byte),
        .rx_byte_valid(rx_byte_valid),
        .cmd_valid(cmd_valid),
        .cmd_op(cmd_op),
        .cmd_val(cmd_val),
        .frame_err(frame_err),
        .cksum_err(cksum_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int last_valid_cyc = 0;
    int unexp_bytes = 0;
    int unexp_cmds = 0;
    int n_frame_err = 0;
    int n_cksum_err = 0;
    int exp_frame_err = 0;
    int exp_cksum_err = 0;
    int excl_viol = 0;
    logic [7:0]  exp_bytes[$];
    logic [23:0] exp_cmds[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_byte_valid && frame_err) excl_viol++;
            if (cmd_valid && cksum_err) excl_viol++;
            if (frame_err) n_frame_err++;
            if (cksum_err) n_cksum_err++;
            if (rx_byte_valid) begin
                last_valid_cyc = cyc;
                if (exp_bytes.size() == 0) unexp_bytes++;
                else check("rx_byte", 32'(rx_byte), 32'(exp_bytes.pop_front()));
            end
            if (cmd_valid) begin
                if (exp_cmds.size() == 0) unexp_cmds++;
                else begin
                    logic [23:0] e;
                    e = exp_cmds.pop_front();
                    check("cmd_op", 32'(cmd_op), 32'(e[23:16]));
                    check("cmd_val", 32'(cmd_val), 32'(e[15:0]));
                end
            end
        end
    end

    // Called at a negedge; leaves rx at the stop level so bytes chain with one stop bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        if (stop_bit) exp_bytes.push_back(b);
        rx = 1'b0;
        start_cyc = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] vh, input logic [7:0] vl,
                              input logic [7:0] ck);
        send_byte(8'h55, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(op, 1'b1);
        send_byte(vh, 1'b1);
        send_byte(vl, 1'b1);
        send_byte(ck, 1'b1);
    endtask

    task automatic settle();
        repeat (30) @(negedge clk);
        check("bytes_pending", 32'(exp_bytes.size()), 0);
        check("cmds_pending", 32'(exp_cmds.size()), 0);
        check("unexp_bytes", 32'(unexp_bytes), 0);
        check("unexp_cmds", 32'(unexp_cmds), 0);
        check("frame_err_cnt", 32'(n_frame_err), 32'(exp_frame_err));
        check("cksum_err_cnt", 32'(n_cksum_err), 32'(exp_cksum_err));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_rx_byte", 32'(rx_byte), 0);
        check("rst_rx_valid", 32'(rx_byte_valid), 0);
        check("rst_cmd_valid", 32'(cmd_valid), 0);
        check("rst_cmd_op", 32'(cmd_op), 0);
        check("rst_cmd_val", 32'(cmd_val), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_cksum_err", 32'(cksum_err), 0);
        repeat (5) @(negedge clk);

        send_byte(8'hA5, 1'b1);
        repeat (10) @(negedge clk);
        check("a5_latency_ok", 32'((last_valid_cyc - start_cyc) <= 10 * CPB + 4), 1);
        settle();

        exp_cmds.push_back({8'h03, 16'h0180});
        send_frame(8'h03, 8'h01, 8'h80, 8'h82);
        settle();

        exp_cksum_err++;
        send_frame(8'h03, 8'h01, 8'h80, 8'h00);
        settle();
        check("hold_cmd_op", 32'(cmd_op), 32'h03);
        check("hold_cmd_val", 32'(cmd_val), 32'h0180);
        exp_cmds.push_back({8'h07, 16'h1234});
        send_frame(8'h07, 8'h12, 8'h34, 8'h21);
        settle();

        exp_frame_err++;
        send_byte(8'h3C, 1'b0);
        repeat (30 * CPB) @(negedge clk);
        rx = 1'b1;
        repeat (24) @(negedge clk);
        exp_cmds.push_back({8'h10, 16'h0005});
        send_frame(8'h10, 8'h00, 8'h05, 8'h15);
        settle();

        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        settle();

        exp_cmds.push_back({8'h01, 16'h1234});
        send_byte(8'h55, 1'b1);
        send_frame(8'h01, 8'h12, 8'h34, 8'h27);
        settle();

        send_byte(8'h55, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h01, 1'b1);
        rx = 1'b1;
        repeat (TMO + 200) @(negedge clk);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h27, 1'b1);
        settle();

        rx = 1'b0;
        repeat (CPB * 4) @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        check("mid_rst_rx_byte", 32'(rx_byte), 0);
        check("mid_rst_cmd_op", 32'(cmd_op), 0);
        check("mid_rst_cmd_val", 32'(cmd_val), 0);
        check("mid_rst_pulses", 32'({rx_byte_valid, cmd_valid, frame_err, cksum_err}), 0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        send_byte(8'h5A, 1'b1);
        settle();
        check("held_rx_byte", 32'(rx_byte), 32'h5A);
        check("exclusive_pulses", 32'(excl_viol), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
